// File: rtl/pipe_control_unit_if.sv
// Handshake/bus bundle between the ID-stage front end and the pipeline control unit.
interface pipe_control_unit_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        stall_in;
  logic        flush_ex;
  logic        id_stall;
  logic        muldiv_busy;
  logic        ex_valid;
  logic        mem_valid;
  logic        wb_valid;
  logic [18:0] ex_ctrl;
  logic [18:0] mem_ctrl;
  logic [18:0] wb_ctrl;
  logic [4:0]  ex_rd;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic        ex_illegal;

  modport master (
    output id_valid, id_instr, stall_in, flush_ex,
    input  id_stall, muldiv_busy, ex_valid, mem_valid, wb_valid,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, stall_in, flush_ex,
    output id_stall, muldiv_busy, ex_valid, mem_valid, wb_valid,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_illegal
  );
endinterface

// File: rtl/pipe_control_unit.sv
// RV32I(M) control unit: decodes ID into a control bundle and carries it through EX/MEM/WB,
// handling load-use bubbles, external stall, branch flush and multi-cycle muldiv hold in EX.
module pipe_control_unit #(
  parameter int unsigned EN_MULDIV  = 0,
  parameter int unsigned MULDIV_LAT = 4
) (
  input logic                 clk,
  input logic                 rst,
  pipe_control_unit_if.slave  bus
);
  localparam int unsigned CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  typedef struct packed {
    logic       muldiv;
    logic [3:0] alu_control;
    logic       next_sel;
    logic       mem_en;
    logic       jalr;
    logic       branch;
    logic       store;
    logic       load;
    logic [1:0] mem_to_reg;
    logic       operand_b;
    logic       operand_a;
    logic [2:0] imm_sel;
    logic       reg_write;
  } ctrl_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {ACT_ADVANCE, ACT_STALL, ACT_HOLD, ACT_FLUSH, ACT_BUBBLE} act_e;

  logic             ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
  ctrl_t            ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic             ex_illegal_q, ex_illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t      dec_ctrl;
  logic       dec_legal, dec_rw, uses_rs1, uses_rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  logic       hold, load_use;
  act_e       act;

  assign funct3 = bus.id_instr[14:12];
  assign funct7 = bus.id_instr[31:25];
  assign rd     = bus.id_instr[11:7];
  assign rs1    = bus.id_instr[19:15];
  assign rs2    = bus.id_instr[24:20];

  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    dec_rw    = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (bus.id_instr[6:0])
      OPC_OP: begin
        dec_rw   = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_ctrl.alu_control = {bus.id_instr[30], funct3};
        if (funct7 == 7'b0000001) begin
          dec_ctrl.muldiv = 1'b1;
          dec_legal       = (EN_MULDIV != 0);
        end else if (funct7 == 7'b0100000) begin
          dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        end else begin
          dec_legal = (funct7 == 7'b0000000);
        end
      end
      OPC_OPIMM: begin
        dec_rw   = 1'b1;
        uses_rs1 = 1'b1;
        dec_ctrl.operand_b   = 1'b1;
        dec_ctrl.alu_control = {bus.id_instr[30] & (funct3 == 3'b101), funct3};
      end
      OPC_LOAD: begin
        dec_rw   = 1'b1;
        uses_rs1 = 1'b1;
        dec_ctrl.load       = 1'b1;
        dec_ctrl.mem_en     = 1'b1;
        dec_ctrl.mem_to_reg = 2'b01;
        dec_ctrl.operand_b  = 1'b1;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_ctrl.store     = 1'b1;
        dec_ctrl.mem_en    = 1'b1;
        dec_ctrl.operand_b = 1'b1;
        dec_ctrl.imm_sel   = 3'b001;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.imm_sel = 3'b010;
      end
      OPC_JAL: begin
        dec_rw = 1'b1;
        dec_ctrl.next_sel   = 1'b1;
        dec_ctrl.mem_to_reg = 2'b10;
        dec_ctrl.operand_a  = 1'b1;
        dec_ctrl.operand_b  = 1'b1;
        dec_ctrl.imm_sel    = 3'b100;
      end
      OPC_JALR: begin
        dec_rw   = 1'b1;
        uses_rs1 = 1'b1;
        dec_ctrl.jalr       = 1'b1;
        dec_ctrl.next_sel   = 1'b1;
        dec_ctrl.mem_to_reg = 2'b10;
        dec_ctrl.operand_b  = 1'b1;
      end
      OPC_LUI: begin
        dec_rw = 1'b1;
        dec_ctrl.operand_b = 1'b1;
        dec_ctrl.imm_sel   = 3'b011;
      end
      OPC_AUIPC: begin
        dec_rw = 1'b1;
        dec_ctrl.operand_a = 1'b1;
        dec_ctrl.operand_b = 1'b1;
        dec_ctrl.imm_sel   = 3'b011;
      end
      default: dec_legal = 1'b0;
    endcase
    dec_ctrl.reg_write = dec_rw && (rd != 5'd0);
    if (!dec_legal) begin
      dec_ctrl = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  assign hold     = ex_valid_q && ex_ctrl_q.muldiv && (cnt_q != '0);
  assign load_use = bus.id_valid && ex_valid_q && ex_ctrl_q.load && (ex_rd_q != 5'd0) &&
                    ((uses_rs1 && (rs1 == ex_rd_q)) || (uses_rs2 && (rs2 == ex_rd_q)));

  always_comb begin
    if (bus.stall_in)     act = ACT_STALL;
    else if (hold)        act = ACT_HOLD;
    else if (bus.flush_ex) act = ACT_FLUSH;
    else if (load_use)    act = ACT_BUBBLE;
    else                  act = ACT_ADVANCE;
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rd_d      = ex_rd_q;
    ex_illegal_d = ex_illegal_q;
    mem_valid_d  = mem_valid_q;
    mem_ctrl_d   = mem_ctrl_q;
    mem_rd_d     = mem_rd_q;
    wb_valid_d   = wb_valid_q;
    wb_ctrl_d    = wb_ctrl_q;
    wb_rd_d      = wb_rd_q;
    cnt_d        = cnt_q;
    if (act != ACT_STALL) begin
      wb_valid_d = mem_valid_q;
      wb_ctrl_d  = mem_ctrl_q;
      wb_rd_d    = mem_rd_q;
      // During a muldiv hold EX keeps its contents and MEM is fed bubbles.
      if (act == ACT_HOLD) begin
        mem_valid_d = 1'b0;
        mem_ctrl_d  = '0;
        mem_rd_d    = '0;
        cnt_d       = cnt_q - CNT_W'(1);
      end else begin
        mem_valid_d  = ex_valid_q;
        mem_ctrl_d   = ex_ctrl_q;
        mem_rd_d     = ex_rd_q;
        ex_valid_d   = 1'b0;
        ex_ctrl_d    = '0;
        ex_rd_d      = '0;
        ex_illegal_d = 1'b0;
        cnt_d        = '0;
        if (act == ACT_ADVANCE && bus.id_valid) begin
          ex_valid_d   = 1'b1;
          ex_ctrl_d    = dec_ctrl;
          ex_rd_d      = dec_ctrl.reg_write ? rd : 5'd0;
          ex_illegal_d = !dec_legal;
          if (dec_ctrl.muldiv) cnt_d = CNT_W'(MULDIV_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rd_q      <= '0;
      ex_illegal_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_ctrl_q   <= '0;
      mem_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_ctrl_q    <= '0;
      wb_rd_q      <= '0;
      cnt_q        <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rd_q      <= ex_rd_d;
      ex_illegal_q <= ex_illegal_d;
      mem_valid_q  <= mem_valid_d;
      mem_ctrl_q   <= mem_ctrl_d;
      mem_rd_q     <= mem_rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_ctrl_q    <= wb_ctrl_d;
      wb_rd_q      <= wb_rd_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.id_stall    = (act == ACT_STALL) || (act == ACT_HOLD) || (act == ACT_BUBBLE);
  assign bus.muldiv_busy = hold;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.mem_ctrl    = mem_ctrl_q;
  assign bus.wb_ctrl     = wb_ctrl_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.ex_illegal  = ex_illegal_q;
endmodule
